// File: rtl/level_sequencer.sv
// level_sequencer: tracks the current game level and sequences the
// level-transition banner shown between rounds.
//
// Ports:
//   clk          system / pixel clock
//   rst_n        asynchronous active-low reset
//   start        start-button pulse (debounced)
//   frame_tick   one pulse per displayed frame
//   level_clear  pulse when all invaders are cleared
//   game_over    pulse when the player has lost
//   level        current level, 1..MAX_LEVEL
//   show_banner  enable for the "LEVEL nn" overlay
//   play_en      high only while gameplay runs
//   level_up     one-cycle pulse per level increment
//   state        FSM state (IDLE=0, BANNER=1, PLAY=2, WIN=3, OVER=4)
//
// Build option: define LEVEL_BANNER_BLINK_EN to blink the banner
// (8 frames on / 8 frames off) when BANNER_FRAMES >= 16.
module level_sequencer #(
    parameter int unsigned MAX_LEVEL     = 15,
    parameter int unsigned BANNER_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       level_clear,
    input  logic       game_over,
    output logic [3:0] level,
    output logic       show_banner,
    output logic       play_en,
    output logic       level_up,
    output logic [2:0] state
);

    localparam int unsigned FCNT_W = (BANNER_FRAMES > 2) ? $clog2(BANNER_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BANNER_FRAMES - 1);
    localparam logic [3:0]        LEVEL_MAX = 4'(MAX_LEVEL);

`ifdef LEVEL_BANNER_BLINK_EN
    // Selects fcnt[3]; zero for short banners so they stay steadily on.
    localparam logic [FCNT_W-1:0] BLINK_MASK =
        (BANNER_FRAMES >= 16) ? FCNT_W'(8) : FCNT_W'(0);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BANNER = 3'd1,
        S_PLAY   = 3'd2,
        S_WIN    = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [FCNT_W-1:0] fcnt;
    logic [FCNT_W-1:0] fcnt_d;
    logic [3:0]        level_d;
    logic              level_up_d;
    logic              play_en_d;
    logic              show_banner_d;

    assign state = state_q;

    // Next-state, counter and output computation.
    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt;
        level_d       = level;
        level_up_d    = 1'b0;
        play_en_d     = 1'b0;
        show_banner_d = 1'b0;

        unique case (state_q)
            S_IDLE, S_WIN, S_OVER: begin
                if (start) begin
                    state_d = S_BANNER;
                    level_d = 4'd1;
                    fcnt_d  = '0;
                end
            end
            S_BANNER: begin
                if (frame_tick) begin
                    if (fcnt == FCNT_LAST) begin
                        state_d = S_PLAY;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt + FCNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                // game_over wins over a coincident level_clear.
                if (game_over) begin
                    state_d = S_OVER;
                end else if (level_clear) begin
                    if (level == LEVEL_MAX) begin
                        state_d = S_WIN;
                    end else begin
                        state_d    = S_BANNER;
                        level_d    = level + 4'd1;
                        level_up_d = 1'b1;
                        fcnt_d     = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                level_d = 4'd1;
                fcnt_d  = '0;
            end
        endcase

        // Outputs follow the next state so they change on the same edge.
        play_en_d = (state_d == S_PLAY);
`ifdef LEVEL_BANNER_BLINK_EN
        show_banner_d = (state_d == S_BANNER) && ((fcnt_d & BLINK_MASK) == FCNT_W'(0));
`else
        show_banner_d = (state_d == S_BANNER);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fcnt        <= '0;
            level       <= 4'd1;
            level_up    <= 1'b0;
            play_en     <= 1'b0;
            show_banner <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt        <= fcnt_d;
            level       <= level_d;
            level_up    <= level_up_d;
            play_en     <= play_en_d;
            show_banner <= show_banner_d;
        end
    end

endmodule
